instr_loader: RTL and testbench

Program loader and instruction store that drives the 16-bit `instruction` input of the single-cycle core. A host streams a program in byte-wise over a valid/ready handshake. The block packs the bytes into 16-bit words and writes them into an on-chip instruction RAM, holding the core in reset while it does so. In RUN it serves one instruction per cycle for the core's PC.

---
 rtl/instr_loader_pkg.sv | 14 +
 rtl/instr_ram.sv | 22 ++
 rtl/instr_loader.sv | 125 ++++++++++++
 tb/tb_instr_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader and its RAM.
package instr_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        RUN
    } state_t;

    localparam logic [15:0] NOP = 16'h0000;
    localparam int unsigned DEFAULT_ADDR_W = 8;

endpackage

// File: rtl/instr_ram.sv
// DEPTH x 16 simple dual-port synchronous RAM: one write port, one registered read port.
module instr_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data
);

    logic [15:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/instr_loader.sv
// Byte-wise program loader into instruction RAM; serves one instruction per cycle in RUN.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_count,
    input  logic              host_valid,
    input  logic [7:0]        host_data,
    output logic              host_ready,
    input  logic [15:0]       pc,
    output logic [15:0]       instruction,
    output logic              core_rst,
    output logic [ADDR_W:0]   loaded_words,
    output logic              fetch_fault
);

    localparam int unsigned   DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, next_state;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   clamped;
    logic [7:0]        low_byte;
    logic              fault_q;
    logic              accept;
    logic              setup;
    logic              wr_en;
    logic [15:0]       rd_data;

    assign clamped    = (load_count > DEPTH_W) ? DEPTH_W : load_count;
    assign host_ready = (state == LOAD_LO) || (state == LOAD_HI);
    assign accept     = host_valid && host_ready;
    assign core_rst   = (state != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        setup      = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    if (clamped != '0) begin
                        next_state = LOAD_LO;
                        setup      = 1'b1;
                    end else begin
                        next_state = RUN;
                    end
                end
            end
            LOAD_LO: begin
                if (accept) begin
                    next_state = LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (accept) begin
                    wr_en      = 1'b1;
                    next_state = (wr_ptr == count - ONE) ? RUN : LOAD_LO;
                end
            end
            RUN: begin
                if (load_start && (clamped != '0)) begin
                    next_state = LOAD_LO;
                    setup      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            count        <= '0;
            loaded_words <= '0;
            low_byte     <= '0;
            fault_q      <= 1'b0;
        end else begin
            if (setup) begin
                wr_ptr       <= '0;
                count        <= clamped;
                loaded_words <= '0;
            end
            if ((state == LOAD_LO) && accept) begin
                low_byte <= host_data;
            end
            if (wr_en) begin
                wr_ptr       <= wr_ptr + ONE;
                loaded_words <= wr_ptr + ONE;
            end
            // Full-width compare so pc values aliasing into the RAM still fault.
            fault_q <= (pc >= 16'(loaded_words));
        end
    end

    instr_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data ({host_data, low_byte}),
        .rd_addr (pc[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // RAM data and fault flag are both registered; gating by state forces NOP outside RUN.
    assign instruction = ((state == RUN) && !fault_q) ? rd_data : NOP;
    assign fetch_fault = (state == RUN) && fault_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader (ADDR_W=4): fetch vector table plus load/reset sequences.
module tb_instr_loader;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW:0]   load_count;
    logic          host_valid;
    logic [7:0]    host_data;
    logic          host_ready;
    logic [15:0]   pc;
    logic [15:0]   instruction;
    logic          core_rst;
    logic [AW:0]   loaded_words;
    logic          fetch_fault;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  bq [$];

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        fault;
    } fvec_t;

    fvec_t tbl [7];

    instr_loader #(
        .ADDR_W (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_count   (load_count),
        .host_valid   (host_valid),
        .host_data    (host_data),
        .host_ready   (host_ready),
        .pc           (pc),
        .instruction  (instruction),
        .core_rst     (core_rst),
        .loaded_words (loaded_words),
        .fetch_fault  (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_load(input logic [AW:0] cnt, input bit with_byte);
        load_count = cnt;
        load_start = 1'b1;
        host_valid = with_byte;
        host_data  = (bq.size() != 0) ? bq[0] : 8'h00;
        step();
        load_start = 1'b0;
        host_valid = 1'b0;
    endtask

    task automatic feed(input bit toggle, output int unsigned cyc);
        int unsigned i;
        logic        acc;
        i   = 0;
        cyc = 0;
        while (i < bq.size() && cyc < 200) begin
            host_valid = toggle ? cyc[0] : 1'b1;
            host_data  = bq[i];
            acc        = host_valid && host_ready;
            step();
            cyc++;
            if (acc) i++;
        end
        host_valid = 1'b0;
        check("feed_done", i, bq.size());
    endtask

    task automatic fetch(input string name, input logic [15:0] p,
                         input logic [15:0] exp_i, input logic exp_f);
        pc = p;
        step();
        check({name, "_instr"}, {16'h0, instruction}, {16'h0, exp_i});
        check({name, "_fault"}, {31'h0, fetch_fault}, {31'h0, exp_f});
    endtask

    task automatic run_table(input string name);
        for (int k = 0; k < 7; k++) begin
            fetch(name, tbl[k].pc, tbl[k].instr, tbl[k].fault);
        end
    endtask

    initial begin
        int unsigned cyc;

        tbl[0] = '{16'h0000, 16'h1234, 1'b0};
        tbl[1] = '{16'h0001, 16'h5678, 1'b0};
        tbl[2] = '{16'h0002, 16'h9ABC, 1'b0};
        tbl[3] = '{16'h0003, 16'h0000, 1'b1};
        tbl[4] = '{16'h0100, 16'h0000, 1'b1};
        tbl[5] = '{16'h0001, 16'h5678, 1'b0};
        tbl[6] = '{16'hFFFF, 16'h0000, 1'b1};

        rst = 1'b1; load_start = 1'b0; load_count = '0;
        host_valid = 1'b0; host_data = 8'h00; pc = 16'h0000;
        step(); step();
        rst = 1'b0;

        // Idle after reset, with host_valid held high to show it is ignored.
        host_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("idle_core_rst", {31'h0, core_rst}, 32'h1);
            check("idle_host_ready", {31'h0, host_ready}, 32'h0);
            check("idle_instr", {16'h0, instruction}, 32'h0);
            check("idle_loaded", {27'h0, loaded_words}, 32'h0);
        end
        host_valid = 1'b0;

        // Count 0 from IDLE: straight to RUN, everything faults.
        start_load('0, 1'b0);
        check("zero_core_rst", {31'h0, core_rst}, 32'h0);
        check("zero_loaded", {27'h0, loaded_words}, 32'h0);
        fetch("zero_pc0", 16'h0000, 16'h0000, 1'b1);

        // 3-word load, valid held; byte offered alongside load_start must not be taken.
        bq = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        start_load(5'd3, 1'b1);
        check("load_core_rst_hi", {31'h0, core_rst}, 32'h1);
        check("load_host_ready", {31'h0, host_ready}, 32'h1);
        feed(1'b0, cyc);
        check("load_latency", 1 + cyc, 32'd7);
        check("load_core_rst_lo", {31'h0, core_rst}, 32'h0);
        check("load_loaded", {27'h0, loaded_words}, 32'd3);
        run_table("held");

        // Overwrite with different data so the toggled load must really rewrite.
        bq = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        start_load(5'd3, 1'b0);
        feed(1'b0, cyc);
        fetch("ovw_pc1", 16'h0001, 16'h2222, 1'b0);

        bq = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        start_load(5'd3, 1'b0);
        feed(1'b1, cyc);
        check("tog_core_rst", {31'h0, core_rst}, 32'h0);
        check("tog_loaded", {27'h0, loaded_words}, 32'd3);
        run_table("toggle");

        // Clamp: count 21 loads only 16 words.
        bq.delete();
        for (int w = 0; w < 16; w++) begin
            bq.push_back(8'(w));
            bq.push_back(8'hA0);
        end
        start_load(5'd21, 1'b0);
        feed(1'b0, cyc);
        check("clamp_latency", 1 + cyc, 32'd33);
        check("clamp_loaded", {27'h0, loaded_words}, 32'd16);
        check("clamp_host_ready", {31'h0, host_ready}, 32'h0);
        check("clamp_core_rst", {31'h0, core_rst}, 32'h0);
        fetch("clamp_pc15", 16'h000F, 16'hA00F, 1'b0);
        fetch("clamp_pc16", 16'h0010, 16'h0000, 1'b1);

        // Count 0 reload while running keeps the existing program.
        start_load('0, 1'b0);
        check("reload0_core_rst", {31'h0, core_rst}, 32'h0);
        check("reload0_loaded", {27'h0, loaded_words}, 32'd16);
        fetch("reload0_pc3", 16'h0003, 16'hA003, 1'b0);
        fetch("reload0_pc0", 16'h0000, 16'hA000, 1'b0);

        // Reset after 3 bytes of a 4-word load.
        bq.delete();
        start_load(5'd4, 1'b0);
        check("reload_core_rst", {31'h0, core_rst}, 32'h1);
        check("reload_loaded", {27'h0, loaded_words}, 32'h0);
        for (int b = 0; b < 3; b++) begin
            host_valid = 1'b1;
            host_data  = 8'h55;
            step();
        end
        check("mid_loaded", {27'h0, loaded_words}, 32'd1);
        rst = 1'b1;
        host_valid = 1'b0;
        step();
        rst = 1'b0;
        check("rst_core_rst", {31'h0, core_rst}, 32'h1);
        check("rst_host_ready", {31'h0, host_ready}, 32'h0);
        check("rst_loaded", {27'h0, loaded_words}, 32'h0);
        check("rst_instr", {16'h0, instruction}, 32'h0);

        bq = '{8'hEF, 8'hBE};
        start_load(5'd1, 1'b0);
        feed(1'b0, cyc);
        check("beef_latency", 1 + cyc, 32'd3);
        check("beef_loaded", {27'h0, loaded_words}, 32'd1);
        fetch("beef_pc0", 16'h0000, 16'hBEEF, 1'b0);
        fetch("beef_pc1", 16'h0001, 16'h0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
